// File: rtl/memory_access.sv
// Memory-stage bus master: one 64-bit load/store per instruction over a valid/ack bus.
// Optional MEM_MISALIGN_CHECK_EN: misaligned requests fail without a bus transaction.
module memory_access #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memRead_M,
  input  logic         memWrite_M,
  input  logic [N-1:0] address_M,
  input  logic [N-1:0] writeData_M,
  output logic [N-1:0] readData_M,
  output logic         done_M,
  output logic         stall_M,
  output logic         error_M,
  output logic         bus_req,
  output logic         bus_we,
  output logic [N-1:0] bus_addr,
  output logic [N-1:0] bus_wdata,
  input  logic         bus_ack,
  input  logic [N-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t         state_reg, state_next;
  logic           bus_req_reg, bus_req_next;
  logic           bus_we_reg, bus_we_next;
  logic [N-1:0]   bus_addr_reg, bus_addr_next;
  logic [N-1:0]   bus_wdata_reg, bus_wdata_next;
  logic [N-1:0]   read_data_reg, read_data_next;
  logic           error_reg, error_next;
  logic [CW-1:0]  count_reg, count_next;

  logic access_req;
  logic misaligned;
  logic timeout_hit;

  assign access_req = memRead_M | memWrite_M;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = (address_M[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  // Counter starts at 0 in the first REQ cycle, so TIMEOUT-1 marks the last allowed cycle.
  assign timeout_hit = (count_reg == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      read_data_reg <= '0;
      error_reg     <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      read_data_reg <= read_data_next;
      error_reg     <= error_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    read_data_next = read_data_reg;
    error_next     = error_reg;
    count_next     = count_reg;

    case (state_reg)
      IDLE: begin
        if (access_req) begin
          if (misaligned) begin
            read_data_next = '0;
            error_next     = 1'b1;
            state_next     = DONE;
          end else begin
            // Write wins when both strobes are high.
            bus_we_next    = memWrite_M;
            bus_addr_next  = address_M;
            bus_wdata_next = writeData_M;
            bus_req_next   = 1'b1;
            count_next     = '0;
            state_next     = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          bus_req_next   = 1'b0;
          read_data_next = bus_we_reg ? '0 : bus_rdata;
          error_next     = 1'b0;
          state_next     = DONE;
        end else if (timeout_hit) begin
          bus_req_next   = 1'b0;
          read_data_next = '0;
          error_next     = 1'b1;
          state_next     = DONE;
        end else if (count_reg != {CW{1'b1}}) begin
          count_next = count_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign done_M     = (state_reg == DONE);
  assign stall_M    = !reset && (((state_reg == IDLE) && access_req) || (state_reg == REQ));
  assign readData_M = read_data_reg;
  assign error_M    = error_reg;
  assign bus_req    = bus_req_reg;
  assign bus_we     = bus_we_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_wdata  = bus_wdata_reg;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: transaction-level model checked every cycle plus directed literal checks.
module tb_memory_access;

  localparam int N       = 64;
  localparam int TIMEOUT = 16;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         memRead_M = 1'b0;
  logic         memWrite_M = 1'b0;
  logic [N-1:0] address_M = '0;
  logic [N-1:0] writeData_M = '0;
  logic [N-1:0] readData_M;
  logic         done_M;
  logic         stall_M;
  logic         error_M;
  logic         bus_req;
  logic         bus_we;
  logic [N-1:0] bus_addr;
  logic [N-1:0] bus_wdata;
  logic         bus_ack = 1'b0;
  logic [N-1:0] bus_rdata = '0;

  memory_access #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .memRead_M(memRead_M), .memWrite_M(memWrite_M),
    .address_M(address_M), .writeData_M(writeData_M),
    .readData_M(readData_M), .done_M(done_M), .stall_M(stall_M), .error_M(error_M),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction view: one outstanding bus access at most, with its age in bus cycles.
  bit           m_active = 0;
  int           m_age = 0;
  bit           m_we = 0;
  logic [N-1:0] m_addr = '0;
  logic [N-1:0] m_wdata = '0;
  bit           m_done = 0;
  logic [N-1:0] m_rdata = '0;
  bit           m_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 0; m_age <= 0; m_we <= 0; m_addr <= '0; m_wdata <= '0;
      m_done <= 0; m_rdata <= '0; m_err <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_active) begin
      if (bus_ack) begin
        m_active <= 0; m_done <= 1; m_err <= 0;
        m_rdata <= m_we ? '0 : bus_rdata;
      end else if (m_age >= TIMEOUT) begin
        m_active <= 0; m_done <= 1; m_err <= 1; m_rdata <= '0;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (memRead_M || memWrite_M) begin
      if (MISALIGN_EN && (address_M[2:0] != 3'b000)) begin
        m_done <= 1; m_err <= 1; m_rdata <= '0;
      end else begin
        m_active <= 1; m_age <= 1; m_we <= memWrite_M;
        m_addr <= address_M; m_wdata <= writeData_M;
      end
    end
  end

  typedef struct {
    string        name;
    logic [N-1:0] act;
    logic [N-1:0] exp;
  } lit_t;
  lit_t lit_q[$];

  task automatic lit(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    lit_t l;
    l.name = name; l.act = act; l.exp = exp;
    lit_q.push_back(l);
  endtask

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  cmp_en = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_stall;
      while (lit_q.size() > 0) begin
        lit_t l;
        l = lit_q.pop_front();
        check(l.name, l.act, l.exp);
      end
      exp_stall = !reset && ((!m_active && !m_done && (memRead_M || memWrite_M)) || m_active);
      check("bus_req", N'(bus_req), N'(m_active));
      check("bus_we", N'(bus_we), N'(m_we));
      check("bus_addr", bus_addr, m_addr);
      check("bus_wdata", bus_wdata, m_wdata);
      check("done_M", N'(done_M), N'(m_done));
      check("readData_M", readData_M, m_rdata);
      check("error_M", N'(error_M), N'(m_err));
      check("stall_M", N'(stall_M), N'(exp_stall));
      $display("cycle %0d: req=%0b we=%0b addr=%h done=%0b err=%0b stall=%0b rdata=%h",
               cyc, bus_req, bus_we, bus_addr, done_M, error_M, stall_M, readData_M);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access starting now (cycle 0); returns on the IDLE cycle after done_M.
  task automatic run_access(input logic rd, input logic wr, input logic [N-1:0] addr,
                            input logic [N-1:0] wd, input int ack_cyc, input logic [N-1:0] rdv,
                            output int n_req, output int n_stall, output int done_c,
                            output int first_req, output logic [N-1:0] a0, output logic we0,
                            output logic [N-1:0] wd0, output logic [N-1:0] rdo, output logic erro);
    n_req = 0; n_stall = 0; done_c = -1; first_req = -1;
    a0 = '0; we0 = 1'b0; wd0 = '0; rdo = '0; erro = 1'b0;
    memRead_M = rd; memWrite_M = wr; address_M = addr; writeData_M = wd; bus_rdata = rdv;
    for (int c = 0; c < 64; c++) begin
      bus_ack = (c == ack_cyc);
      #1;
      if (stall_M) n_stall++;
      if (bus_req) begin
        n_req++;
        if (first_req < 0) begin
          first_req = cyc; a0 = bus_addr; we0 = bus_we; wd0 = bus_wdata;
        end
      end
      if (done_M) begin
        done_c = c; rdo = readData_M; erro = error_M;
        memRead_M = 1'b0; memWrite_M = 1'b0; bus_ack = 1'b0;
        break;
      end
      step();
    end
    bus_ack = 1'b0; memRead_M = 1'b0; memWrite_M = 1'b0;
    lit("done_seen", N'(done_c >= 0), N'(1));
    step();
  endtask

  initial begin
    int n_req, n_stall, done_c, fr1, fr2;
    logic [N-1:0] a0, wd0, rdo;
    logic we0, erro;

    repeat (3) step();
    cmp_en = 1;
    lit("reset_done", N'(done_M), N'(0));
    lit("reset_busreq", N'(bus_req), N'(0));
    reset = 1'b0;
    step();

    // Load 0x40, ack in cycle 1.
    run_access(1, 0, 64'h40, 64'h0, 1, 64'h1122334455667788,
               n_req, n_stall, done_c, fr1, a0, we0, wd0, rdo, erro);
    $display("load 0x40: done_c=%0d stall=%0d rdata=%h err=%0b", done_c, n_stall, rdo, erro);
    lit("ld_done_cycle", N'(done_c), N'(2));
    lit("ld_stall_cycles", N'(n_stall), N'(2));
    lit("ld_rdata", rdo, 64'h1122334455667788);
    lit("ld_err", N'(erro), N'(0));
    lit("ld_addr", a0, 64'h40);

    // Store 0x80 <- 0xDEAD, ack in cycle 5.
    run_access(0, 1, 64'h80, 64'hDEAD, 5, 64'hFFFF_FFFF,
               n_req, n_stall, done_c, fr1, a0, we0, wd0, rdo, erro);
    $display("store 0x80: req_cycles=%0d done_c=%0d rdata=%h", n_req, done_c, rdo);
    lit("st_req_cycles", N'(n_req), N'(5));
    lit("st_we", N'(we0), N'(1));
    lit("st_addr", a0, 64'h80);
    lit("st_wdata", wd0, 64'hDEAD);
    lit("st_rdata", rdo, 64'h0);
    lit("st_done_cycle", N'(done_c), N'(6));

    // No ack: timeout.
    run_access(1, 0, 64'h100, 64'h0, -1, 64'h1234,
               n_req, n_stall, done_c, fr1, a0, we0, wd0, rdo, erro);
    $display("timeout: req_cycles=%0d done_c=%0d err=%0b", n_req, done_c, erro);
    lit("to_req_cycles", N'(n_req), N'(16));
    lit("to_done_cycle", N'(done_c), N'(17));
    lit("to_err", N'(erro), N'(1));
    lit("to_rdata", rdo, 64'h0);
    bus_ack = 1'b1;
    step();
    lit("stray_ack_done", N'(done_M), N'(0));
    step();
    lit("stray_ack_done2", N'(done_M), N'(0));
    lit("stray_ack_req", N'(bus_req), N'(0));
    bus_ack = 1'b0;
    step();

    // Both strobes: write wins.
    run_access(1, 1, 64'h8, 64'h55, 2, 64'hFFFF,
               n_req, n_stall, done_c, fr1, a0, we0, wd0, rdo, erro);
    $display("rd+wr: we=%0b rdata=%h", we0, rdo);
    lit("both_we", N'(we0), N'(1));
    lit("both_rdata", rdo, 64'h0);
    lit("both_err", N'(erro), N'(0));

    // Back-to-back load then store.
    run_access(1, 0, 64'h10, 64'h0, 1, 64'hA5A5,
               n_req, n_stall, done_c, fr1, a0, we0, wd0, rdo, erro);
    lit("b2b_ld_rdata", rdo, 64'hA5A5);
    run_access(0, 1, 64'h18, 64'h77, 1, 64'h0,
               n_req, n_stall, done_c, fr2, a0, we0, wd0, rdo, erro);
    $display("back-to-back: first req cycle %0d, second %0d", fr1, fr2);
    lit("b2b_spacing", N'(fr2 - fr1), N'(3));

    // Reset asserted in REQ cycle 3.
    memRead_M = 1'b1; address_M = 64'h20; bus_rdata = 64'hBEEF;
    step(); step(); step();
    reset = 1'b1;
    #1;
    lit("rst_stall", N'(stall_M), N'(0));
    step();
    reset = 1'b0; memRead_M = 1'b0; bus_ack = 1'b1;
    #1;
    lit("rst_req", N'(bus_req), N'(0));
    lit("rst_addr", bus_addr, 64'h0);
    lit("rst_done", N'(done_M), N'(0));
    step();
    bus_ack = 1'b0;
    #1;
    lit("late_ack_done", N'(done_M), N'(0));
    $display("reset mid-access: req=%0b done=%0b", bus_req, done_M);
    step();

    // Misaligned load at 0x43.
    run_access(1, 0, 64'h43, 64'h0, 2, 64'hABC,
               n_req, n_stall, done_c, fr1, a0, we0, wd0, rdo, erro);
    $display("load 0x43: req_cycles=%0d done_c=%0d err=%0b addr=%h", n_req, done_c, erro, a0);
    if (MISALIGN_EN) begin
      lit("mis_req_cycles", N'(n_req), N'(0));
      lit("mis_done_cycle", N'(done_c), N'(1));
      lit("mis_err", N'(erro), N'(1));
      lit("mis_stall", N'(n_stall), N'(1));
      lit("mis_rdata", rdo, 64'h0);
    end else begin
      lit("mis_addr", a0, 64'h43);
      lit("mis_req_cycles", N'(n_req), N'(2));
      lit("mis_done_cycle", N'(done_c), N'(3));
      lit("mis_rdata", rdo, 64'hABC);
      lit("mis_err", N'(erro), N'(0));
    end

    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
